// File: rtl/imem_fetch_arb_pkg.sv
// imem_fetch_arb_pkg
//   Shared definitions for the dual-core instruction fetch arbiter:
//   FSM state encoding, halt opcode, core ids and a halt-word helper.
//   The optional halt detection is enabled by defining HALT_DETECT_EN.
package imem_fetch_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic [5:0] OPC_HALT = 6'h3F;
  localparam logic       CORE0    = 1'b0;
  localparam logic       CORE1    = 1'b1;

  // Opcode field lives in the top six bits of a 32-bit instruction word.
  function automatic logic is_halt(input logic [31:0] w);
    return w[31:26] == OPC_HALT;
  endfunction

endpackage

// File: rtl/imem_fetch_arb_rr_arb2.sv
// rr_arb2
//   Two-way round-robin picker. When both requesters are eligible the one
//   that was NOT served last wins; a lone eligible requester always wins.
// Ports
//   eligible[1:0]  in   per-core eligibility (request and not halted)
//   last           in   core id served most recently
//   owner          out  chosen core id (don't-care when any=0)
//   any            out  at least one core eligible
module rr_arb2
  import imem_fetch_arb_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       last,
  output logic       owner,
  output logic       any
);

  always_comb begin
    any   = |eligible;
    owner = CORE0;
    if (eligible == 2'b11) owner = ~last;
    else if (eligible[1])  owner = CORE1;
  end

endmodule

// File: rtl/imem_fetch_arb.sv
// imem_fetch_arb
//   Shares one single-port instruction ROM between two cores. Requests are
//   arbitrated round-robin, one fetch is in flight at a time
//   (IDLE -> ISSUE -> WAIT x MEM_LAT -> RESP -> IDLE), and each core's
//   fetched word is held in a per-core register until its next fetch.
//   Optional feature macro: HALT_DETECT_EN -- a captured word with opcode
//   6'h3F sets that core's halted flag, which masks its requests until reset.
// Ports
//   clk, reset_n         clock, synchronous active-low reset
//   req0/req1            fetch request per core, held until validX
//   pc0/pc1              fetch PC per core, sampled at grant (low ADDR_W bits)
//   gnt0/gnt1            core owns the ROM, ISSUE..RESP inclusive
//   valid0/valid1        one-cycle pulse, instrX updated this cycle
//   instr0/instr1        per-core registered instruction
//   mem_en, mem_addr     ROM read strobe (one cycle) and latched word address
//   mem_rdata            ROM data, valid MEM_LAT cycles after mem_en
//   halted[1:0]          per-core halt flags (0 when HALT_DETECT_EN undefined)
// MEM_LAT legal range is 1..4.
module imem_fetch_arb
  import imem_fetch_arb_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [31:0]       pc0,
  input  logic [31:0]       pc1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              valid0,
  output logic              valid1,
  output logic [DATA_W-1:0] instr0,
  output logic [DATA_W-1:0] instr1,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        halted
);

  // Counter value on the final WAIT cycle, when mem_rdata is valid.
  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

  state_e                   state_q;
  logic                     owner_q;
  logic                     last_q;
  logic [2:0]               cnt_q;
  logic [1:0]               gnt_q;
  logic [1:0]               valid_q;
  logic                     mem_en_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [1:0][DATA_W-1:0]   instr_q;

  logic [1:0]               elig;
  logic                     pick;
  logic                     pick_any;
  logic [ADDR_W-1:0]        addr_pick;

  // Upper PC bits are architecturally ignored.
  logic unused_pc_hi;
  assign unused_pc_hi = ^{pc0[31:ADDR_W], pc1[31:ADDR_W]};

`ifdef HALT_DETECT_EN
  logic [1:0] halted_q;
  assign elig   = {req1, req0} & ~halted_q;
  assign halted = halted_q;
`else
  assign elig   = {req1, req0};
  assign halted = 2'b00;
`endif

  rr_arb2 u_arb (
    .eligible (elig),
    .last     (last_q),
    .owner    (pick),
    .any      (pick_any)
  );

  assign addr_pick = pick ? pc1[ADDR_W-1:0] : pc0[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      owner_q  <= CORE0;
      last_q   <= CORE1;   // core0 wins the first contested slot
      cnt_q    <= '0;
      gnt_q    <= '0;
      valid_q  <= '0;
      mem_en_q <= 1'b0;
      addr_q   <= '0;
      instr_q  <= '0;
`ifdef HALT_DETECT_EN
      halted_q <= '0;
`endif
    end else begin
      valid_q  <= '0;
      mem_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick_any) begin
            // Address is latched here so later PC changes cannot disturb it.
            owner_q  <= pick;
            addr_q   <= addr_pick;
            gnt_q    <= pick ? 2'b10 : 2'b01;
            mem_en_q <= 1'b1;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == LAT_LAST) begin
            instr_q[owner_q] <= mem_rdata;
            valid_q[owner_q] <= 1'b1;
`ifdef HALT_DETECT_EN
            if (is_halt(mem_rdata[31:0])) halted_q[owner_q] <= 1'b1;
`endif
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        S_RESP: begin
          gnt_q   <= '0;
          last_q  <= owner_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt0     = gnt_q[0];
  assign gnt1     = gnt_q[1];
  assign valid0   = valid_q[0];
  assign valid1   = valid_q[1];
  assign instr0   = instr_q[0];
  assign instr1   = instr_q[1];
  assign mem_en   = mem_en_q;
  assign mem_addr = addr_q;

endmodule
